byte_addr_mem: RTL
==================

BYTE_ADDR_MEM -- requirements
Module: byte_addr_mem

Interface
REQ-001 Parameter WORD_BYTES, default 4: bytes per internal storage word; power of two, 2..8.
REQ-002 Parameter DEPTH_WORDS, default 16: number of storage words; power of two.
REQ-003 Parameter ADDR_W, default 6: byte-address width; SHALL equal log2(WORD_BYTES*DEPTH_WORDS).
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  block can accept a request this cycle.
REQ-009 req_we  in  1  1 = write, 0 = read.
REQ-010 req_size  in  2  0 = byte, 1 = half (2 B), 2 = word (WORD_BYTES B), 3 = illegal.
REQ-011 req_addr  in  ADDR_W  byte address; any alignment.
REQ-012 req_wdata  in  8*WORD_BYTES  write value, right-justified in the LSBs.
REQ-013 big_endian  in  1  byte-order select, sampled at request accept.
REQ-014 rsp_valid  out  1  one-cycle completion pulse; no backpressure.
REQ-015 rsp_rdata  out  8*WORD_BYTES  read value, zero-extended; 0 for writes and errors.
REQ-016 rsp_err  out  1  qualifies rsp_valid; 1 = illegal size.

Function
REQ-017 Accept: a request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-018 Addressing: the block SHALL be byte-addressed; byte a lives in word a/WORD_BYTES.
REQ-019 Access span: an access of N bytes at address A SHALL touch bytes A..A+N-1, each taken modulo 2^ADDR_W, so the top address wraps to 0.
REQ-020 Byte order: with big_endian=0, byte A SHALL be the LSB of the N-byte value; with big_endian=1, byte A SHALL be the MSB.
REQ-021 Writes: a write SHALL modify only the N addressed bytes, using the N low bytes of req_wdata.
REQ-022 FSM: the FSM SHALL have two states, IDLE and SPLIT; req_ready SHALL be 1 in IDLE and 0 in SPLIT.
REQ-023 Single-word access: if the span lies in one storage word (or size=3), the FSM SHALL stay in IDLE, and rsp_valid SHALL pulse exactly 1 cycle after accept.
REQ-024 Back-to-back: consecutive single-word requests SHALL be accepted on consecutive cycles.
REQ-025 Split access: if the span crosses a word boundary (including the wrap from the last word to word 0), the FSM SHALL go IDLE→SPLIT for exactly one cycle, then SPLIT→IDLE, and rsp_valid SHALL pulse 2 cycles after accept.
REQ-026 Split commit: in a split access, the lower-address word SHALL be accessed at the accept edge and the second word at the SPLIT edge; request fields SHALL be latched at accept.
REQ-027 Write visibility: write data SHALL be committed by the edge on which rsp_valid rises, so a read accepted on that edge or later returns the new data.
REQ-028 Illegal size: size=3 SHALL give rsp_err=1, rsp_rdata=0 and no memory change, with single-cycle latency.
REQ-029 Idle outputs: rsp_valid, rsp_err and rsp_rdata SHALL be 0 in every cycle without a response.
REQ-030 Request held in SPLIT: a request presented while req_ready=0 SHALL NOT be accepted, and SHALL be accepted on the first cycle back in IDLE if still valid.

Reset
REQ-031 Output values under rst_n=0: FSM=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0.
REQ-032 Memory contents under rst_n=0: every byte a SHALL be initialised to a[7:0].
REQ-033 Reset during SPLIT: an in-flight access SHALL be aborted with no response generated, and memory SHALL be re-initialised per REQ-032.

Verification
REQ-034 Aligned word read: after reset (defaults), word read at 0x04 -> rsp 1 cycle later = 0x07060504 with big_endian=0, and 0x04050607 with big_endian=1.
REQ-035 Split half read: half read at 0x03, big_endian=0 -> req_ready low 1 cycle, rsp 2 cycles after accept = 0x00000403.
REQ-036 Wrapped word write: word write 0x12345678 at 0x3E, big_endian=0 (split with wrap) -> later byte reads return 0x78 @0x3E, 0x56 @0x3F, 0x34 @0x00, 0x12 @0x01.
REQ-037 Read-after-write: byte write 0x41 at 0x02, then word read at 0x00 with big_endian=1 accepted the next cycle -> rsp_rdata = 0x00014103.
REQ-038 Illegal size: size=3 read at 0x08 -> rsp_valid=1, rsp_err=1, rsp_rdata=0; a following byte read at 0x08 returns 0x08.
REQ-039 Reset mid-split: rst_n low during SPLIT of a split write -> no rsp_valid; after release, req_ready=1 and all bytes read back as their own addresses.

Source files
------------

// File: rtl/byte_addr_mem.sv
// byte_addr_mem: byte-addressed storage with byte/half/word accesses at any
// alignment. Accesses that straddle two storage words (including the wrap
// from the top address to 0) take one extra SPLIT cycle. Byte order is
// selectable per request.
module byte_addr_mem #(
  parameter int WORD_BYTES  = 4,
  parameter int DEPTH_WORDS = 16,
  parameter int ADDR_W      = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [1:0]              req_size,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [8*WORD_BYTES-1:0] req_wdata,
  input  logic                    big_endian,
  output logic                    rsp_valid,
  output logic [8*WORD_BYTES-1:0] rsp_rdata,
  output logic                    rsp_err
);

  localparam int DW    = 8 * WORD_BYTES;
  localparam int TOTAL = WORD_BYTES * DEPTH_WORDS;
  localparam int OFF_W = $clog2(WORD_BYTES);
  localparam int NB_W  = $clog2(WORD_BYTES) + 1;

  typedef enum logic {IDLE, SPLIT} state_e;

  state_e            state_q, state_d;
  logic [7:0]        mem_q [TOTAL];
  logic [7:0]        mem_d [TOTAL];
  // Request fields held for the second half of a split access
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic              be_q, be_d;
  logic [NB_W-1:0]   n_q, n_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  // Read bytes gathered from the first word of a split access
  logic [DW-1:0]     acc_q, acc_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;

  // Byte count for a legal size code; illegal size touches nothing
  function automatic logic [NB_W-1:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'd0:    size_bytes = NB_W'(1);
      2'd1:    size_bytes = NB_W'(2);
      2'd2:    size_bytes = NB_W'(WORD_BYTES);
      default: size_bytes = '0;
    endcase
  endfunction

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  // Byte-lane access for the current phase plus next-state/response logic.
  // In IDLE only bytes in the word holding the start address are touched;
  // in SPLIT only the remaining bytes (in the following word) are.
  always_comb begin
    logic              in_split;
    logic              fire;
    logic [ADDR_W-1:0] cur_addr;
    logic              cur_we;
    logic              cur_be;
    logic [NB_W-1:0]   cur_n;
    logic [DW-1:0]     cur_wdata;
    logic [ADDR_W-1:0] a_i;
    logic [ADDR_W-1:0] last;
    logic              first_word;
    logic              crosses;
    logic [DW-1:0]     acc;
    int                pos;

    state_d     = state_q;
    mem_d       = mem_q;
    addr_d      = addr_q;
    we_d        = we_q;
    be_d        = be_q;
    n_d         = n_q;
    wdata_d     = wdata_q;
    acc_d       = acc_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    acc         = '0;
    a_i         = '0;
    first_word  = 1'b0;
    pos         = 0;

    in_split  = (state_q == SPLIT);
    fire      = req_valid && !in_split;
    cur_addr  = in_split ? addr_q  : req_addr;
    cur_we    = in_split ? we_q    : req_we;
    cur_be    = in_split ? be_q    : big_endian;
    cur_wdata = in_split ? wdata_q : req_wdata;
    cur_n     = in_split ? n_q     : size_bytes(req_size);

    last    = req_addr + ADDR_W'(size_bytes(req_size)) - ADDR_W'(1);
    crosses = last[ADDR_W-1:OFF_W] != req_addr[ADDR_W-1:OFF_W];

    for (int i = 0; i < WORD_BYTES; i++) begin
      if ((fire || in_split) && i < int'(cur_n)) begin
        a_i        = cur_addr + ADDR_W'(i);
        first_word = a_i[ADDR_W-1:OFF_W] == cur_addr[ADDR_W-1:OFF_W];
        if (first_word != in_split) begin
          pos = cur_be ? int'(cur_n) - 1 - i : i;
          if (cur_we) mem_d[a_i] = cur_wdata[pos*8 +: 8];
          else        acc[pos*8 +: 8] = mem_q[a_i];
        end
      end
    end

    if (in_split) begin
      state_d     = IDLE;
      rsp_valid_d = 1'b1;
      rsp_rdata_d = we_q ? '0 : (acc_q | acc);
    end else if (fire) begin
      if (req_size == 2'd3) begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
      end else if (crosses) begin
        state_d = SPLIT;
        addr_d  = req_addr;
        we_d    = req_we;
        be_d    = big_endian;
        n_d     = size_bytes(req_size);
        wdata_d = req_wdata;
        acc_d   = acc;
      end else begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = req_we ? '0 : acc;
      end
    end
  end

  // State, memory and response registers; reset loads each byte with its address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      for (int a = 0; a < TOTAL; a++) mem_q[a] <= 8'(a);
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= 1'b0;
      n_q         <= '0;
      wdata_q     <= '0;
      acc_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      be_q        <= be_d;
      n_q         <= n_d;
      wdata_q     <= wdata_d;
      acc_q       <= acc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule
